mem_bus_arbiter: RTL and testbench



---
 rtl/mem_bus_arbiter_pkg.sv | 35 +++
 rtl/mem_bus_arbiter_picker.sv | 55 +++++
 rtl/mem_bus_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// Shared configuration for the memory-bus arbiter slice.
//
//   main_memory_config : main-memory address and block-data widths.
//   bus_arbiter_config : arbitration policy and FSM state encodings, plus the
//                        winner-index width helper used by the arbiter and
//                        its picker.
// ---------------------------------------------------------------------------

package main_memory_config;
    localparam int MAIN_MEMORY_ADDRESS_WIDTH = 32;
    localparam int MAIN_MEMORY_DATA_WIDTH    = 64;
endpackage

package bus_arbiter_config;

    typedef enum logic {
        ARB_ROUND_ROBIN    = 1'b0,
        ARB_FIXED_PRIORITY = 1'b1
    } arb_mode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RESPOND = 2'd2
    } arb_state_t;

    localparam int WAIT_CNT_W = 16;

    // Winner index width; never narrower than one bit.
    function automatic int arb_idx_width(input int num_ports);
        return (num_ports > 2) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_picker.sv
// ---------------------------------------------------------------------------
// rr_priority_picker - combinational winner selection.
//
// Ports:
//   i_req   : per-port request vector
//   i_ptr   : round-robin search start index (ignored in fixed priority)
//   i_mode  : ARB_ROUND_ROBIN or ARB_FIXED_PRIORITY
//   o_grant : one-hot winner (zero when no request)
//   o_idx   : binary index of the winner
//   o_valid : at least one request present
// ---------------------------------------------------------------------------

module rr_priority_picker
    import bus_arbiter_config::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = arb_idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_ptr,
    input  arb_mode_t            i_mode,
    output logic [NUM_PORTS-1:0] o_grant,
    output logic [IDX_W-1:0]     o_idx,
    output logic                 o_valid
);

    localparam logic [IDX_W:0] NP = (IDX_W+1)'(NUM_PORTS);

    logic [IDX_W-1:0] w_start;
    logic [IDX_W:0]   w_pos;

    // Fixed priority is simply a round-robin search that always starts at 0.
    assign w_start = (i_mode == ARB_ROUND_ROBIN) ? i_ptr : '0;

    // Walk ports starting at w_start, wrapping NUM_PORTS-1 -> 0; the one extra
    // bit in w_pos holds the un-wrapped sum so a single subtract folds it back.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            w_pos = {1'b0, w_start} + (IDX_W+1)'(k);
            if (w_pos >= NP) begin
                w_pos = w_pos - NP;
            end
            if (!o_valid && i_req[w_pos[IDX_W-1:0]]) begin
                o_valid                    = 1'b1;
                o_idx                      = w_pos[IDX_W-1:0];
                o_grant[w_pos[IDX_W-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter - shares one main-memory port between NUM_PORTS caches.
//
// One transaction at a time: IDLE picks a winner and latches its op, address
// and data; ISSUE holds the memory request until main_memory_ready; RESPOND
// pulses port_ready to the owner for one cycle, then back to IDLE.
//
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   port_read_request[N]          : per-port block read request
//   port_write_request[N]         : per-port write-back request (wins over read)
//   port_address[N][ADDR_W]       : per-port address
//   port_write_data[N][DATA_W]    : per-port write-back data
//   port_grant[N]                 : one-hot bus owner, visible during ISSUE
//   port_ready[N]                 : one-cycle completion pulse (RESPOND)
//   port_read_data[DATA_W]        : shared read data, valid with port_ready
//   main_memory_read_request      : memory read request (ISSUE, read op)
//   main_memory_write_request     : memory write request (ISSUE, write op)
//   main_memory_address[ADDR_W]   : latched address
//   main_memory_write_data[DATA_W]: latched write data
//   main_memory_read_data[DATA_W] : memory read data, sampled with ready
//   main_memory_ready             : memory completion
// ---------------------------------------------------------------------------

module mem_bus_arbiter
    import main_memory_config::*;
    import bus_arbiter_config::*;
#(
    parameter int        NUM_PORTS = 4,
    parameter int        ADDR_W    = MAIN_MEMORY_ADDRESS_WIDTH,
    parameter int        DATA_W    = MAIN_MEMORY_DATA_WIDTH,
    parameter arb_mode_t ARB_MODE  = ARB_ROUND_ROBIN
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             port_read_request,
    input  logic [NUM_PORTS-1:0]             port_write_request,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0] port_address,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0] port_write_data,
    output logic [NUM_PORTS-1:0]             port_grant,
    output logic [NUM_PORTS-1:0]             port_ready,
    output logic [DATA_W-1:0]                port_read_data,
    output logic                             main_memory_read_request,
    output logic                             main_memory_write_request,
    output logic [ADDR_W-1:0]                main_memory_address,
    output logic [DATA_W-1:0]                main_memory_write_data,
    input  logic [DATA_W-1:0]                main_memory_read_data,
    input  logic                             main_memory_ready
);

    localparam int               IDX_W    = arb_idx_width(NUM_PORTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

    arb_state_t             r_state;
    arb_state_t             w_state_next;

    logic [NUM_PORTS-1:0]   w_req;
    logic [NUM_PORTS-1:0]   w_pick_grant;
    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_pick_valid;
    logic [NUM_PORTS-1:0]   w_take;
    logic [IDX_W-1:0]       w_rr_ptr_next;

    logic [NUM_PORTS-1:0]   r_owner;
    logic                   r_is_write;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_wdata;
    logic [DATA_W-1:0]      r_rdata;
    logic [IDX_W-1:0]       r_rr_ptr;
    logic [WAIT_CNT_W-1:0]  r_wait_cnt [NUM_PORTS];

    assign w_req = port_read_request | port_write_request;

    rr_priority_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .i_mode  (ARB_MODE),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_rr_ptr_next = (w_pick_idx == LAST_IDX) ? '0 : w_pick_idx + 1'b1;
    assign w_take        = (r_state == IDLE && w_pick_valid) ? w_pick_grant : '0;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_pick_valid)      w_state_next = ISSUE;
            ISSUE:   if (main_memory_ready) w_state_next = RESPOND;
            RESPOND: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        port_grant                = '0;
        port_ready                = '0;
        main_memory_read_request  = 1'b0;
        main_memory_write_request = 1'b0;
        unique case (r_state)
            ISSUE: begin
                port_grant                = r_owner;
                main_memory_read_request  = !r_is_write;
                main_memory_write_request = r_is_write;
            end
            RESPOND: port_ready = r_owner;
            default: ;
        endcase
    end

    assign main_memory_address    = r_addr;
    assign main_memory_write_data = r_wdata;
    assign port_read_data         = r_rdata;

    // ---------------- Transaction datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner    <= '0;
            r_is_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_rr_ptr   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_owner    <= w_pick_grant;
                        // Read+write together is serviced as the write-back.
                        r_is_write <= port_write_request[w_pick_idx];
                        r_addr     <= port_address[w_pick_idx];
                        r_wdata    <= port_write_data[w_pick_idx];
                        if (ARB_MODE == ARB_ROUND_ROBIN) begin
                            r_rr_ptr <= w_rr_ptr_next;
                        end
                    end
                end
                ISSUE: begin
                    if (main_memory_ready && !r_is_write) begin
                        r_rdata <= main_memory_read_data;
                    end
                end
                RESPOND: r_owner <= '0;
                default: ;
            endcase
        end
    end

    // Starvation counters: count cycles spent requesting while not owning the
    // bus; cleared on the pick edge and for as long as the port owns it.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (reset || w_take[i] || r_owner[i]) begin
                r_wait_cnt[i] <= '0;
            end else if (w_req[i] && (r_wait_cnt[i] != '1)) begin
                r_wait_cnt[i] <= r_wait_cnt[i] + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// Directed bench for mem_bus_arbiter. Two instances share every input: dut is
// round-robin (default parameters), dut_fp is fixed priority. Inputs change
// and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------

module tb_mem_bus_arbiter;
    import main_memory_config::*;
    import bus_arbiter_config::*;

    localparam int NP = 4;
    localparam int AW = MAIN_MEMORY_ADDRESS_WIDTH;
    localparam int DW = MAIN_MEMORY_DATA_WIDTH;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NP-1:0]            port_read_request;
    logic [NP-1:0]            port_write_request;
    logic [NP-1:0][AW-1:0]    port_address;
    logic [NP-1:0][DW-1:0]    port_write_data;
    logic [DW-1:0]            main_memory_read_data;
    logic                     main_memory_ready;

    logic [NP-1:0]            port_grant, port_ready;
    logic [DW-1:0]            port_read_data;
    logic                     mm_rreq, mm_wreq;
    logic [AW-1:0]            mm_addr;
    logic [DW-1:0]            mm_wdata;

    logic [NP-1:0]            fp_grant, fp_ready;
    logic [DW-1:0]            fp_read_data;
    logic                     fp_rreq, fp_wreq;
    logic [AW-1:0]            fp_addr;
    logic [DW-1:0]            fp_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk                       (clk),
        .reset                     (reset),
        .port_read_request         (port_read_request),
        .port_write_request        (port_write_request),
        .port_address              (port_address),
        .port_write_data           (port_write_data),
        .port_grant                (port_grant),
        .port_ready                (port_ready),
        .port_read_data            (port_read_data),
        .main_memory_read_request  (mm_rreq),
        .main_memory_write_request (mm_wreq),
        .main_memory_address       (mm_addr),
        .main_memory_write_data    (mm_wdata),
        .main_memory_read_data     (main_memory_read_data),
        .main_memory_ready         (main_memory_ready)
    );

    mem_bus_arbiter #(
        .NUM_PORTS (NP),
        .ARB_MODE  (ARB_FIXED_PRIORITY)
    ) dut_fp (
        .clk                       (clk),
        .reset                     (reset),
        .port_read_request         (port_read_request),
        .port_write_request        (port_write_request),
        .port_address              (port_address),
        .port_write_data           (port_write_data),
        .port_grant                (fp_grant),
        .port_ready                (fp_ready),
        .port_read_data            (fp_read_data),
        .main_memory_read_request  (fp_rreq),
        .main_memory_write_request (fp_wreq),
        .main_memory_address       (fp_addr),
        .main_memory_write_data    (fp_wdata),
        .main_memory_read_data     (main_memory_read_data),
        .main_memory_ready         (main_memory_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [NP-1:0] rr_exp [5];
    int fp_r0, fp_r2, fp_g2;

    initial begin
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // ---- reset with requests pending: everything stays zero ----
        reset                 = 1'b1;
        port_read_request     = 4'hF;
        port_write_request    = '0;
        port_address          = '0;
        port_write_data       = '0;
        main_memory_read_data = '0;
        main_memory_ready     = 1'b0;
        @(negedge clk);
        step();
        step();
        chk("rst_grant",  port_grant, 0);
        chk("rst_ready",  port_ready, 0);
        chk("rst_rdata",  port_read_data, 0);
        chk("rst_rreq",   mm_rreq, 0);
        chk("rst_wreq",   mm_wreq, 0);
        chk("rst_addr",   mm_addr, 0);
        chk("rst_wdata",  mm_wdata, 0);
        chk("rst_state",  dut.r_state, IDLE);
        chk("rst_rrptr",  dut.r_rr_ptr, 0);
        chk("rst_fpgnt",  fp_grant, 0);

        port_read_request = '0;
        reset             = 1'b0;
        step();
        chk("idle_grant", port_grant, 0);

        // ---- single read, port 1, memory ready on 2nd ISSUE cycle ----
        port_address[0]   = 32'h1111_1111;
        port_address[1]   = 32'h0000_1000;
        port_read_request = 4'b0010;
        chk("t1_pre_grant", port_grant, 0);
        step();
        chk("t1_grant", port_grant, 4'b0010);
        chk("t1_rreq",  mm_rreq, 1);
        chk("t1_wreq",  mm_wreq, 0);
        chk("t1_addr",  mm_addr, 32'h0000_1000);
        chk("t1_fpgnt", fp_grant, 4'b0010);
        port_read_request = '0;
        port_address[1]   = 32'hFFFF_0000;
        step();
        chk("t1_hold_rreq", mm_rreq, 1);
        chk("t1_hold_addr", mm_addr, 32'h0000_1000);
        chk("t1_hold_rdy",  port_ready, 0);
        main_memory_ready     = 1'b1;
        main_memory_read_data = 64'h0123_4567_DEAD_BEEF;
        step();
        chk("t1_ready", port_ready, 4'b0010);
        chk("t1_rdata", port_read_data, 64'h0123_4567_DEAD_BEEF);
        chk("t1_rreq_off", mm_rreq, 0);
        chk("t1_grant_off", port_grant, 0);
        main_memory_ready     = 1'b0;
        main_memory_read_data = '0;
        step();
        chk("t1_ready_off", port_ready, 0);
        chk("t1_state", dut.r_state, IDLE);
        chk("t1_rrptr", dut.r_rr_ptr, 2);

        // ---- write-back, port 3 ----
        port_address[3]    = 32'hA000_0000;
        port_write_data[3] = 64'hCAFE_F00D_DEAD_BEEF;
        port_write_request = 4'b1000;
        step();
        chk("t2_grant", port_grant, 4'b1000);
        chk("t2_wreq",  mm_wreq, 1);
        chk("t2_rreq",  mm_rreq, 0);
        chk("t2_addr",  mm_addr, 32'hA000_0000);
        chk("t2_wdata", mm_wdata, 64'hCAFE_F00D_DEAD_BEEF);
        port_write_request = '0;
        port_write_data[3] = '0;
        port_address[3]    = '0;
        step();
        chk("t2_hold_wreq",  mm_wreq, 1);
        chk("t2_hold_addr",  mm_addr, 32'hA000_0000);
        chk("t2_hold_wdata", mm_wdata, 64'hCAFE_F00D_DEAD_BEEF);
        main_memory_ready = 1'b1;
        step();
        chk("t2_ready", port_ready, 4'b1000);
        chk("t2_wreq_off", mm_wreq, 0);
        main_memory_ready = 1'b0;
        step();
        chk("t2_rrptr", dut.r_rr_ptr, 0);

        // ---- read+write on port 0: write first, then the held read ----
        main_memory_ready     = 1'b1;
        main_memory_read_data = 64'h1111_2222_3333_4444;
        port_address[0]       = 32'h0000_0040;
        port_write_data[0]    = 64'h5555;
        port_read_request     = 4'b0001;
        port_write_request    = 4'b0001;
        step();
        chk("t3_wr_wreq",  mm_wreq, 1);
        chk("t3_wr_rreq",  mm_rreq, 0);
        chk("t3_wr_grant", port_grant, 4'b0001);
        step();
        chk("t3_wr_ready", port_ready, 4'b0001);
        port_write_request = '0;
        step();
        chk("t3_gap_grant", port_grant, 0);
        chk("t3_gap_ready", port_ready, 0);
        step();
        chk("t3_rd_rreq", mm_rreq, 1);
        chk("t3_rd_wreq", mm_wreq, 0);
        port_read_request = '0;
        step();
        chk("t3_rd_ready", port_ready, 4'b0001);
        chk("t3_rd_rdata", port_read_data, 64'h1111_2222_3333_4444);
        step();

        // ---- round robin from rr_ptr=0, all four ports, memory always ready ----
        reset = 1'b1;
        step();
        chk("rr_rst_ptr", dut.r_rr_ptr, 0);
        reset             = 1'b0;
        port_read_request = 4'hF;
        for (int t = 0; t < 5; t++) begin
            step();
            chk($sformatf("rr_grant%0d", t), port_grant, rr_exp[t]);
            step();
            chk($sformatf("rr_ready%0d", t), port_ready, rr_exp[t]);
            step();
            if (t == 3) begin
                chk("rr_w0_a", dut.r_wait_cnt[0], 9);
                chk("rr_w1_a", dut.r_wait_cnt[1], 6);
                chk("rr_w2_a", dut.r_wait_cnt[2], 3);
                chk("rr_w3_a", dut.r_wait_cnt[3], 0);
            end
        end
        chk("rr_w0_b", dut.r_wait_cnt[0], 0);
        chk("rr_w1_b", dut.r_wait_cnt[1], 9);
        chk("rr_w2_b", dut.r_wait_cnt[2], 6);
        chk("rr_w3_b", dut.r_wait_cnt[3], 3);

        // ---- reset while in ISSUE: request drops, no port_ready ----
        port_read_request = '0;
        step();
        main_memory_ready = 1'b0;
        port_address[2]   = 32'h2222_0000;
        port_read_request = 4'b0100;
        step();
        chk("ri_rreq",  mm_rreq, 1);
        chk("ri_grant", port_grant, 4'b0100);
        reset = 1'b1;
        step();
        chk("ri_grant0", port_grant, 0);
        chk("ri_ready0", port_ready, 0);
        chk("ri_rreq0",  mm_rreq, 0);
        chk("ri_wreq0",  mm_wreq, 0);
        chk("ri_addr0",  mm_addr, 0);
        chk("ri_wdata0", mm_wdata, 0);
        chk("ri_rdata0", port_read_data, 0);
        chk("ri_state",  dut.r_state, IDLE);
        reset             = 1'b0;
        port_read_request = '0;
        step();
        chk("ri_no_ready", port_ready, 0);
        chk("ri_state2",   dut.r_state, IDLE);

        // ---- fixed priority: ports 0 and 2 forever, port 2 starves ----
        reset = 1'b1;
        step();
        reset             = 1'b0;
        main_memory_ready = 1'b1;
        port_read_request = 4'b0101;
        fp_r0 = 0;
        fp_r2 = 0;
        fp_g2 = 0;
        for (int c = 0; c < 66000; c++) begin
            step();
            if (fp_ready[0]) fp_r0++;
            if (fp_ready[2]) fp_r2++;
            if (fp_grant[2]) fp_g2++;
        end
        chk("fp_ready0_cnt", fp_r0, 22000);
        chk("fp_ready2_cnt", fp_r2, 0);
        chk("fp_grant2_cnt", fp_g2, 0);
        chk("fp_wait2_sat",  dut_fp.r_wait_cnt[2], 16'hFFFF);
        chk("fp_wait0",      dut_fp.r_wait_cnt[0], 0);
        chk("fp_wait1",      dut_fp.r_wait_cnt[1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
